spi_frame_rx: RTL and testbench

SPI_FRAME_RX -- requirements
Module: spi_frame_rx

---
 rtl/spi_frame_pkg.sv | 21 ++
 rtl/spi_frame_sync.sv | 49 ++++
 rtl/spi_frame_rx.sv | 170 +++++++++++++++++
 tb/tb_spi_frame_rx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI frame receiver: FSM states, command codes, field widths.
package spi_frame_pkg;

  localparam int unsigned CMD_W      = 8;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FRAME_BITS = CMD_W + ADDR_W + DATA_W;

  localparam logic [7:0] CMD_WRITE    = 8'h02;
  localparam logic [7:0] CMD_QUAD_ON  = 8'h01;
  localparam logic [7:0] CMD_QUAD_OFF = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    ISSUE
  } state_e;

endpackage

// File: rtl/spi_frame_sync.sv
// SYNC_STAGES-deep synchroniser for the SPI pins into clk_i, with sclk rise and cs fall detection.
module spi_frame_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sclk_i,
  input  logic       cs_i,
  input  logic [3:0] sdi_i,
  output logic       sclk_rise_o,
  output logic       cs_o,
  output logic       cs_fall_o,
  output logic [3:0] sdi_o
);

  logic [SYNC_STAGES-1:0]      sclk_q;
  logic [SYNC_STAGES-1:0]      cs_q;
  logic [SYNC_STAGES-1:0][3:0] sdi_q;
  logic                        sclk_prev_q;
  logic                        cs_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_q      <= '0;
      cs_q        <= '1;
      sdi_q       <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_q[0] <= sclk_i;
      cs_q[0]   <= cs_i;
      sdi_q[0]  <= sdi_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sclk_q[i] <= sclk_q[i-1];
        cs_q[i]   <= cs_q[i-1];
        sdi_q[i]  <= sdi_q[i-1];
      end
      sclk_prev_q <= sclk_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_q[SYNC_STAGES-1];
    end
  end

  // sdi travels through the same depth as sclk, so it is aligned with the detected edge
  assign sclk_rise_o = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign cs_o        = cs_q[SYNC_STAGES-1];
  assign cs_fall_o   = ~cs_q[SYNC_STAGES-1] & cs_prev_q;
  assign sdi_o       = sdi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_frame_rx.sv
// SPI (mode 0) write-frame receiver issuing 32-bit memory writes.
// Optional quad-lane receive enabled by macro SPI_FRAME_RX_QUAD_EN.
module spi_frame_rx
  import spi_frame_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        spi_sclk,
  input  logic        spi_cs,
  output logic [1:0]  spi_mode,
  input  logic        spi_sdi0,
  input  logic        spi_sdi1,
  input  logic        spi_sdi2,
  input  logic        spi_sdi3,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  output logic        frame_err_o
);

  logic       sclk_rise;
  logic       cs_s;
  logic       cs_fall;
  logic [3:0] sdi_s;

  state_e      state_q, state_d;
  logic [6:0]  cnt_q;
  logic [6:0]  cnt_inc;
  logic [6:0]  step;
  logic [7:0]  cmd_q;
  logic [7:0]  cmd_next;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        err_q, err_d;
  logic        is_write;
  logic        shifting;

  spi_frame_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .sclk_i      (spi_sclk),
    .cs_i        (spi_cs),
    .sdi_i       ({spi_sdi3, spi_sdi2, spi_sdi1, spi_sdi0}),
    .sclk_rise_o (sclk_rise),
    .cs_o        (cs_s),
    .cs_fall_o   (cs_fall),
    .sdi_o       (sdi_s)
  );

`ifdef SPI_FRAME_RX_QUAD_EN
  logic quad_q;
  assign step = quad_q ? 7'd4 : 7'd1;
`else
  logic unused_sdi;
  assign unused_sdi = ^sdi_s[3:1];
  assign step       = 7'd1;
`endif

  assign cnt_inc  = cnt_q + step;
  assign cmd_next = {cmd_q[6:0], sdi_s[0]};
  assign is_write = (cmd_q == CMD_WRITE);
  // the counter parks at FRAME_BITS so a discarded frame ignores trailing edges
  assign shifting = sclk_rise && (state_q inside {CMD, ADDR, DATA}) && (cnt_q != 7'(FRAME_BITS));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (cs_fall) state_d = CMD;
      CMD: begin
        if (cs_s) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (sclk_rise && cnt_q == 7'(CMD_W - 1)) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (cs_s) begin
          state_d = IDLE;
          err_d   = is_write;
        end else if (sclk_rise && cnt_inc == 7'(CMD_W + ADDR_W)) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (cs_s) begin
          state_d = IDLE;
          err_d   = is_write && (cnt_q != 7'(FRAME_BITS));
        end else if (shifting && is_write && cnt_inc == 7'(FRAME_BITS)) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        err_d = cs_fall;
        if (bus_gnt_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_req_o   = (state_q == ISSUE);
    bus_addr_o  = addr_q;
    bus_wdata_o = data_q;
    frame_err_o = err_q;
`ifdef SPI_FRAME_RX_QUAD_EN
    spi_mode    = quad_q ? 2'b10 : 2'b00;
`else
    spi_mode    = 2'b00;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      cmd_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
`ifdef SPI_FRAME_RX_QUAD_EN
      quad_q <= 1'b0;
`endif
    end else begin
      err_q <= err_d;
      if (state_q == IDLE && state_d == CMD) begin
        cnt_q <= '0;
      end else if (shifting) begin
        unique case (state_q)
          CMD: begin
            cnt_q <= cnt_q + 7'd1;
            cmd_q <= cmd_next;
`ifdef SPI_FRAME_RX_QUAD_EN
            if (state_d == ADDR && cmd_next == CMD_QUAD_ON)  quad_q <= 1'b1;
            if (state_d == ADDR && cmd_next == CMD_QUAD_OFF) quad_q <= 1'b0;
`endif
          end
          ADDR: begin
            cnt_q <= cnt_inc;
`ifdef SPI_FRAME_RX_QUAD_EN
            if (is_write) addr_q <= quad_q ? {addr_q[27:0], sdi_s} : {addr_q[30:0], sdi_s[0]};
`else
            if (is_write) addr_q <= {addr_q[30:0], sdi_s[0]};
`endif
          end
          DATA: begin
            cnt_q <= cnt_inc;
`ifdef SPI_FRAME_RX_QUAD_EN
            if (is_write) data_q <= quad_q ? {data_q[27:0], sdi_s} : {data_q[30:0], sdi_s[0]};
`else
            if (is_write) data_q <= {data_q[30:0], sdi_s[0]};
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed self-checking bench for spi_frame_rx; quad-lane steps build with SPI_FRAME_RX_QUAD_EN.
module tb_spi_frame_rx;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_sdi0 = 1'b0, spi_sdi1 = 1'b0, spi_sdi2 = 1'b0, spi_sdi3 = 1'b0;
  logic        bus_gnt = 1'b0;
  logic [1:0]  spi_mode;
  logic        bus_req;
  logic [31:0] bus_addr, bus_wdata;
  logic        frame_err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned err_cnt = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];

  always #5 clk = ~clk;

  spi_frame_rx #(.SYNC_STAGES(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .spi_sclk    (spi_sclk),
    .spi_cs      (spi_cs),
    .spi_mode    (spi_mode),
    .spi_sdi0    (spi_sdi0),
    .spi_sdi1    (spi_sdi1),
    .spi_sdi2    (spi_sdi2),
    .spi_sdi3    (spi_sdi3),
    .bus_req_o   (bus_req),
    .bus_addr_o  (bus_addr),
    .bus_wdata_o (bus_wdata),
    .bus_gnt_i   (bus_gnt),
    .frame_err_o (frame_err)
  );

  // grant only changes 1ns after posedge, so negedge sampling sees the value of the next edge
  always @(negedge clk) begin
    if (rst_ni) begin
      if (bus_req && bus_gnt) begin
        q_addr.push_back(bus_addr);
        q_data.push_back(bus_wdata);
      end
      if (frame_err) err_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_xfer(input string tag, input logic [31:0] ea, input logic [31:0] ed);
    logic [31:0] a, d;
    if (q_addr.size() == 0) begin
      check({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      a = q_addr.pop_front();
      d = q_data.pop_front();
      check({tag, "_addr"}, a, ea);
      check({tag, "_data"}, d, ed);
    end
  endtask

  task automatic set_gnt(input logic v);
    @(posedge clk);
    #1 bus_gnt = v;
  endtask

  // mode 0: data changes while sclk low, sclk period 60ns (6 clk periods)
  task automatic spi_send(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                          input int unsigned nbits, input bit quad);
    logic [71:0] f;
    logic [3:0]  nib;
    int unsigned pos;
    f = {cmd, addr, data};
    pos = 0;
    spi_cs = 1'b0;
    #60;
    while (pos < nbits) begin
      if (pos < 8 || !quad) begin
        spi_sdi0 = f[71 - pos];
        pos += 1;
      end else begin
        nib = f[71 - pos -: 4];
        {spi_sdi3, spi_sdi2, spi_sdi1, spi_sdi0} = nib;
        pos += 4;
      end
      #30 spi_sclk = 1'b1;
      #30 spi_sclk = 1'b0;
    end
    #60 spi_cs = 1'b1;
    #60;
  endtask

  initial begin
    int unsigned e0;
    int unsigned x0;
    bit stable;

    // reset state
    #3;
    check("rst_req", bus_req, 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_err", frame_err, 32'd0);
    check("rst_mode", spi_mode, 32'd0);
    #40 rst_ni = 1'b1;
    repeat (5) @(negedge clk);

    // single write, grant tied high
    set_gnt(1'b1);
    spi_send(8'h02, 32'h80, 32'h0000_0fff, 72, 1'b0);
    repeat (20) @(negedge clk);
    check("t1_count", 32'(q_addr.size()), 32'd1);
    expect_xfer("t1", 32'h80, 32'h0000_0fff);
    check("t1_noerr", err_cnt, 32'd0);

    // 32 back-to-back frames, 10 sclk periods apart
    for (int i = 0; i < 32; i++) begin
      spi_send(8'h02, 32'h80 + 32'(4 * i), 32'hC0DE_0000 | 32'(i * 32'h111), 72, 1'b0);
      #600;
    end
    check("t2_count", 32'(q_addr.size()), 32'd32);
    for (int i = 0; i < 32; i++)
      expect_xfer($sformatf("t2_%0d", i), 32'h80 + 32'(4 * i), 32'hC0DE_0000 | 32'(i * 32'h111));
    check("t2_noerr", err_cnt, 32'd0);

    // grant withheld, second frame arrives while the request is pending
    set_gnt(1'b0);
    spi_send(8'h02, 32'h200, 32'h1234_5678, 72, 1'b0);
    for (int i = 0; i < 50 && !bus_req; i++) @(negedge clk);
    check("t3_req_seen", bus_req, 32'd1);
    e0 = err_cnt;
    stable = 1'b1;
    fork
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (!(bus_req === 1'b1 && bus_addr === 32'h200 && bus_wdata === 32'h1234_5678)) stable = 1'b0;
      end
      spi_send(8'h02, 32'h300, 32'hCAFE_F00D, 72, 1'b0);
    join
    check("t3_stable50", 32'(stable), 32'd1);
    check("t3_still_req", bus_req, 32'd1);
    check("t3_still_addr", bus_addr, 32'h200);
    check("t3_still_data", bus_wdata, 32'h1234_5678);
    check("t3_err_pulse", err_cnt - e0, 32'd1);
    check("t3_no_xfer_yet", 32'(q_addr.size()), 32'd0);
    set_gnt(1'b1);
    repeat (100) @(negedge clk);
    check("t3_count", 32'(q_addr.size()), 32'd1);
    expect_xfer("t3", 32'h200, 32'h1234_5678);
    check("t3_req_low", bus_req, 32'd0);

    // abort after 40 bits, then a normal frame
    e0 = err_cnt;
    spi_send(8'h02, 32'h400, 32'h0000_0055, 40, 1'b0);
    repeat (20) @(negedge clk);
    check("t4_no_xfer", 32'(q_addr.size()), 32'd0);
    check("t4_err_pulse", err_cnt - e0, 32'd1);
    spi_send(8'h02, 32'h404, 32'hA5A5_A5A5, 72, 1'b0);
    repeat (20) @(negedge clk);
    check("t4_count", 32'(q_addr.size()), 32'd1);
    expect_xfer("t4", 32'h404, 32'hA5A5_A5A5);

    // unknown command
    e0 = err_cnt;
    spi_send(8'h05, 32'h500, 32'h1111_1111, 72, 1'b0);
    repeat (20) @(negedge clk);
    check("t5_no_xfer", 32'(q_addr.size()), 32'd0);
    check("t5_no_err", err_cnt - e0, 32'd0);

`ifdef SPI_FRAME_RX_QUAD_EN
    // quad on, quad write
    spi_send(8'h01, 32'h0, 32'h0, 8, 1'b0);
    repeat (10) @(negedge clk);
    check("q_mode_on", spi_mode, 32'h2);
    spi_send(8'h02, 32'h100, 32'hDEAD_BEEF, 72, 1'b1);
    repeat (20) @(negedge clk);
    check("q_mode_kept", spi_mode, 32'h2);
    check("q_count", 32'(q_addr.size()), 32'd1);
    expect_xfer("q", 32'h100, 32'hDEAD_BEEF);
`else
    // quad commands are unknown in this build
    e0 = err_cnt;
    spi_send(8'h01, 32'h0, 32'h0, 8, 1'b0);
    spi_send(8'h02, 32'h100, 32'hDEAD_BEEF, 72, 1'b0);
    repeat (20) @(negedge clk);
    check("s_mode", spi_mode, 32'h0);
    check("s_no_err", err_cnt - e0, 32'd0);
    expect_xfer("s", 32'h100, 32'hDEAD_BEEF);
`endif

    // reset with a pending request and a frame in flight
    set_gnt(1'b0);
    spi_send(8'h02, 32'h600, 32'h2222_3333, 72, 1'b0);
    for (int i = 0; i < 50 && !bus_req; i++) @(negedge clk);
    check("r_req_before", bus_req, 32'd1);
    x0 = 32'(q_addr.size());
    fork
      spi_send(8'h02, 32'h700, 32'h4444_5555, 20, 1'b0);
    join_none
    #502 rst_ni = 1'b0;
    #1;
    check("r_req", bus_req, 32'd0);
    check("r_addr", bus_addr, 32'd0);
    check("r_wdata", bus_wdata, 32'd0);
    check("r_mode", spi_mode, 32'd0);
    #2000 rst_ni = 1'b1;
    set_gnt(1'b1);
    repeat (30) @(negedge clk);
    check("r_no_xfer", 32'(q_addr.size()) - x0, 32'd0);
    check("r_mode_after", spi_mode, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
